// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    UPD  = 2'd2
  } state_t;

  localparam logic [1:0] EVT_PELLET = 2'd0;
  localparam logic [1:0] EVT_POWER  = 2'd1;
  localparam logic [1:0] EVT_FRUIT  = 2'd2;
  localparam logic [1:0] EVT_GHOST  = 2'd3;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/score_bcd_digit_add.sv
// Single-digit BCD adder with carry; reused for every digit of a score addition.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] s_adj;

  assign s     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s_adj = s - 5'd10;

  always_comb begin
    sum  = s[3:0];
    cout = 1'b0;
    if (s > 5'd9) begin
      sum  = s_adj[3:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_bcd.sv
// Game score keeper: digit-serial BCD accumulation, session high score and
// display/decimal-point drive for the 7-segment scanner.
module score_bcd
  import score_pkg::*;
#(
  parameter logic [15:0] PTS_PELLET = 16'h0010,
  parameter logic [15:0] PTS_POWER  = 16'h0050,
  parameter logic [15:0] PTS_FRUIT  = 16'h0100,
  parameter logic [15:0] PTS_GHOST  = 16'h0200,
  parameter int          BLINK_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        evt_valid,
  input  logic [1:0]  evt_code,
  output logic        evt_ready,
  input  logic        show_hi,
  output logic [15:0] disp_num,
  output logic [3:0]  dpdot
);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           k;
  logic                 carry;
  logic [15:0]          score;
  logic [15:0]          hi;
  logic                 new_hi;
  logic [15:0]          work;
  logic [15:0]          inc;
  logic [BLINK_W-1:0]   blink;
  logic                 accept;
  logic [3:0]           dig_a;
  logic [3:0]           dig_b;
  logic [3:0]           dig_sum;
  logic                 dig_cout;

  function automatic logic [15:0] pts_of(input logic [1:0] code);
    logic [15:0] p;
    case (code)
      EVT_PELLET: p = PTS_PELLET;
      EVT_POWER:  p = PTS_POWER;
      EVT_FRUIT:  p = PTS_FRUIT;
      default:    p = PTS_GHOST;
    endcase
    return p;
  endfunction

  assign accept = evt_valid & evt_ready & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    evt_ready = 1'b0;
    case (state)
      IDLE: begin
        evt_ready = 1'b1;
        if (evt_valid) state_nxt = ADD;
      end
      ADD:     if (k == 2'd3) state_nxt = UPD;
      UPD:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // One digit per cycle, selected by k, through a single shared adder.
  assign dig_a = work[{k, 2'b00} +: 4];
  assign dig_b = inc[{k, 2'b00} +: 4];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= 2'd0;
      carry  <= 1'b0;
      score  <= 16'h0000;
      hi     <= 16'h0000;
      new_hi <= 1'b0;
    end else if (clr) begin
      k      <= 2'd0;
      carry  <= 1'b0;
      score  <= 16'h0000;
      new_hi <= 1'b0;
    end else if (accept) begin
      k     <= 2'd0;
      carry <= 1'b0;
    end else if (state == ADD) begin
      k     <= k + 2'd1;
      carry <= dig_cout;
      // Top digit's sum is not yet in work, so splice it in on commit.
      if (k == 2'd3) score <= dig_cout ? BCD_MAX : {dig_sum, work[11:0]};
    end else if (state == UPD) begin
      if (score > hi) begin
        hi     <= score;
        new_hi <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      work <= score;
      inc  <= pts_of(evt_code);
    end else if (state == ADD) begin
      work[{k, 2'b00} +: 4] <= dig_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink <= '0;
    else        blink <= blink + BLINK_W'(1);
  end

  assign disp_num = show_hi ? hi : score;
  assign dpdot    = {4{new_hi & blink[BLINK_W-1]}};

endmodule

// File: tb/tb_score_bcd.sv
// Directed bench for score_bcd: vector table of event batches plus
// hand-written sequences for latency, back-to-back, clr and reset corners.
module tb_score_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        evt_valid = 1'b0;
  logic [1:0]  evt_code = 2'd0;
  logic        evt_ready;
  logic        show_hi = 1'b0;
  logic [15:0] disp_num;
  logic [3:0]  dpdot;

  int tests = 0;
  int fails = 0;

  score_bcd #(.BLINK_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .show_hi   (show_hi),
    .disp_num  (disp_num),
    .dpdot     (dpdot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_clr;
    logic [1:0]  code;
    int          n;
    logic        show;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!evt_ready && w < 20) begin
      tick();
      w++;
    end
    check(name, {31'd0, evt_ready}, 32'd1);
  endtask

  task automatic send_evt(input logic [1:0] code);
    wait_ready("ready_before_evt");
    evt_valid = 1'b1;
    evt_code  = code;
    tick();
    evt_valid = 1'b0;
    wait_ready("ready_after_evt");
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic show(input logic sel);
    show_hi = sel;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_on, seen_off, bad, accepts, last, gap_bad;

    vecs[0]  = '{1'b1, 2'd0, 1,  1'b0, 16'h0010};
    vecs[1]  = '{1'b0, 2'd0, 8,  1'b0, 16'h0090};
    vecs[2]  = '{1'b0, 2'd1, 1,  1'b0, 16'h0140};
    vecs[3]  = '{1'b0, 2'd0, 0,  1'b1, 16'h0140};
    vecs[4]  = '{1'b0, 2'd3, 4,  1'b0, 16'h0940};
    vecs[5]  = '{1'b0, 2'd2, 9,  1'b0, 16'h1840};
    vecs[6]  = '{1'b1, 2'd2, 1,  1'b0, 16'h0100};
    vecs[7]  = '{1'b0, 2'd0, 0,  1'b1, 16'h1840};
    vecs[8]  = '{1'b1, 2'd3, 49, 1'b0, 16'h9800};
    vecs[9]  = '{1'b0, 2'd1, 3,  1'b0, 16'h9950};
    vecs[10] = '{1'b0, 2'd3, 1,  1'b0, 16'h9999};
    vecs[11] = '{1'b0, 2'd0, 1,  1'b0, 16'h9999};
    vecs[12] = '{1'b0, 2'd0, 0,  1'b1, 16'h9999};

    // Reset state
    tick();
    tick();
    check("rst_disp", {16'd0, disp_num}, 32'h0);
    check("rst_dpdot", {28'd0, dpdot}, 32'h0);
    check("rst_ready", {31'd0, evt_ready}, 32'd1);
    show(1'b1);
    check("rst_hi", {16'd0, disp_num}, 32'h0);
    show(1'b0);
    rst_n = 1'b1;
    tick();

    // First pellet: latency of score and hi
    evt_valid = 1'b1;
    evt_code  = 2'd0;
    tick();                                        // T
    evt_valid = 1'b0;
    check("lat_ready_T", {31'd0, evt_ready}, 32'd0);
    tick(); tick(); tick();                        // T+3
    check("lat_score_T3", {16'd0, disp_num}, 32'h0);
    tick();                                        // T+4
    check("lat_score_T4", {16'd0, disp_num}, 32'h0010);
    show(1'b1);
    check("lat_hi_T4", {16'd0, disp_num}, 32'h0);
    check("lat_ready_T4", {31'd0, evt_ready}, 32'd0);
    tick();                                        // T+5
    check("lat_hi_T5", {16'd0, disp_num}, 32'h0010);
    check("lat_ready_T5", {31'd0, evt_ready}, 32'd1);
    show(1'b0);
    seen_on = 0; seen_off = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (dpdot == 4'hF) seen_on++;
      else if (dpdot == 4'h0) seen_off++;
      else bad++;
      tick();
    end
    check("dpdot_lit", {31'd0, seen_on > 0}, 32'd1);
    check("dpdot_dark", {31'd0, seen_off > 0}, 32'd1);
    check("dpdot_legal", bad, 32'd0);

    // Event batches from the vector table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_clr) do_clr();
      for (int j = 0; j < vecs[i].n; j++) send_evt(vecs[i].code);
      show(vecs[i].show);
      check($sformatf("vec%0d", i), {16'd0, disp_num}, {16'd0, vecs[i].exp});
      show(1'b0);
    end

    // New high score flashing; clr stops it while hi is kept
    seen_on = 0;
    for (int i = 0; i < 20; i++) begin
      if (dpdot == 4'hF) seen_on++;
      tick();
    end
    check("newhi_flash", {31'd0, seen_on > 0}, 32'd1);
    do_clr();
    send_evt(2'd2);
    check("clr_fruit_score", {16'd0, disp_num}, 32'h0100);
    show(1'b1);
    check("clr_keeps_hi", {16'd0, disp_num}, 32'h9999);
    show(1'b0);
    seen_on = 0;
    for (int i = 0; i < 20; i++) begin
      if (dpdot != 4'h0) seen_on++;
      tick();
    end
    check("clr_dpdot_off", seen_on, 32'd0);

    // clr together with evt_valid: event must be refused
    evt_valid = 1'b1;
    evt_code  = 2'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt_valid = 1'b0;
    check("clr_blocks_evt_ready", {31'd0, evt_ready}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("clr_blocks_evt_score", {16'd0, disp_num}, 32'h0);

    // 100 pellets with evt_valid held high
    evt_code  = 2'd0;
    evt_valid = 1'b1;
    accepts = 0; last = 0; gap_bad = 0;
    for (int c = 0; c < 1000 && accepts < 100; c++) begin
      if (evt_ready) begin
        if (accepts > 0 && c - last != 6) gap_bad++;
        last = c;
        accepts++;
      end
      tick();
    end
    evt_valid = 1'b0;
    wait_ready("b2b_done");
    check("b2b_accepts", accepts, 32'd100);
    check("b2b_spacing", gap_bad, 32'd0);
    check("b2b_score", {16'd0, disp_num}, 32'h1000);

    // clr while the adder is on digit 2
    wait_ready("k2_ready");
    evt_valid = 1'b1;
    evt_code  = 2'd2;
    tick();                                        // T
    evt_valid = 1'b0;
    tick(); tick();                                // T+2, k=2
    clr = 1'b1;
    tick();                                        // T+3
    clr = 1'b0;
    check("k2clr_score", {16'd0, disp_num}, 32'h0);
    check("k2clr_ready", {31'd0, evt_ready}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("k2clr_no_commit", {16'd0, disp_num}, 32'h0);
    show(1'b1);
    check("k2clr_hi", {16'd0, disp_num}, 32'h9999);
    show(1'b0);

    // Asynchronous reset in the middle of an addition
    send_evt(2'd0);
    check("pre_rst_score", {16'd0, disp_num}, 32'h0010);
    evt_valid = 1'b1;
    evt_code  = 2'd3;
    tick();
    evt_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_score", {16'd0, disp_num}, 32'h0);
    check("arst_ready", {31'd0, evt_ready}, 32'd1);
    check("arst_dpdot", {28'd0, dpdot}, 32'h0);
    show(1'b1);
    check("arst_hi", {16'd0, disp_num}, 32'h0);
    show(1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("arst_no_commit", {16'd0, disp_num}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
